// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared widths, geometry defaults and FSM encodings for icache.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int c_INDEX_W = 5;
    localparam int c_TAG_W   = 11;
    localparam int c_XLEN    = 32;
    localparam int c_BYTE_W  = 8;

    localparam int         c_ST_W      = 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_REFILL = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_array
// Description : Direct-mapped data/tag storage, one async read port, one write
//               port, valid bits in flops with single-cycle bulk clear.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = c_INDEX_W,
    parameter int TAG_W   = c_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [c_XLEN-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [c_XLEN-1:0]  wr_data,
    input  logic               clear_all
);

    localparam int c_LINES = 1 << INDEX_W;

    logic [c_XLEN-1:0] r_data [c_LINES];
    logic [TAG_W-1:0]  r_tag  [c_LINES];
    logic [c_LINES-1:0] r_valid;

    // Bulk clear wins over a same-cycle install.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (clear_all) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_data[wr_idx] <= wr_data;
            r_tag[wr_idx]  <= wr_tag;
        end
    end

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_data  = r_data[rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped instruction cache, one word per line, refilled
//               four bytes at a time over a granted byte bus.
// Revision    : 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = c_INDEX_W,
    parameter int TAG_W   = c_TAG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic [c_XLEN-1:0]   addr_i,
    input  logic                cancel_i,
    input  logic                flush_i,
    output logic [c_XLEN-1:0]   inst_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                mem_req_o,
    output logic [c_XLEN-1:0]   mem_addr_o,
    input  logic                mem_grant_i,
    input  logic [c_BYTE_W-1:0] mem_din
);

    localparam int c_WA_W  = INDEX_W + TAG_W;
    localparam int c_PAD_W = c_XLEN - c_WA_W - 2;

    logic [c_ST_W-1:0] r_state;
    logic [c_WA_W-1:0] r_waddr;
    logic [2:0]        r_issue_cnt;
    logic              r_pend;
    logic [1:0]        r_cap_idx;
    logic [23:0]       r_buf;
    logic              r_cancel;
    logic              r_flush;
    logic              r_valid;
    logic [c_XLEN-1:0] r_inst;

    logic [INDEX_W-1:0] w_idx_in;
    logic [TAG_W-1:0]   w_tag_in;
    logic               w_rd_valid;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [c_XLEN-1:0]  w_rd_data;
    logic               w_accept;
    logic               w_hit;
    logic               w_issue;
    logic               w_last;
    logic               w_wr_en;
    logic [1:0]         w_k;
    logic [c_XLEN-1:0]  w_word;
    logic               w_unused;

    assign w_idx_in = addr_i[INDEX_W+1:2];
    assign w_tag_in = addr_i[c_WA_W+1:INDEX_W+2];
    assign w_unused = ^{addr_i[c_XLEN-1:c_WA_W+2], addr_i[1:0]};

    assign w_accept = (r_state == c_ST_IDLE) & req_i & ~cancel_i;
    assign w_hit    = w_accept & ~flush_i & w_rd_valid & (w_rd_tag == w_tag_in);
    // Counter value 4 means all bytes are on their way; no further issues.
    assign w_issue  = (r_state == c_ST_REFILL) & mem_grant_i & ~r_issue_cnt[2];
    assign w_last   = (r_state == c_ST_REFILL) & r_pend & (r_cap_idx == 2'd3);
    assign w_wr_en  = w_last & ~r_flush & ~flush_i;
    assign w_k      = r_issue_cnt[2] ? 2'd3 : r_issue_cnt[1:0];
    assign w_word   = {mem_din, r_buf};

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (w_idx_in),
        .rd_valid  (w_rd_valid),
        .rd_tag    (w_rd_tag),
        .rd_data   (w_rd_data),
        .wr_en     (w_wr_en),
        .wr_idx    (r_waddr[INDEX_W-1:0]),
        .wr_tag    (r_waddr[c_WA_W-1:INDEX_W]),
        .wr_data   (w_word),
        .clear_all (flush_i)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_waddr     <= '0;
            r_issue_cnt <= '0;
            r_pend      <= 1'b0;
            r_cap_idx   <= '0;
            r_buf       <= '0;
            r_cancel    <= 1'b0;
            r_flush     <= 1'b0;
            r_valid     <= 1'b0;
            r_inst      <= '0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_cap_idx   <= r_issue_cnt[1:0];
                r_issue_cnt <= r_issue_cnt + 3'd1;
            end
            if ((r_state == c_ST_REFILL) && r_pend) begin
                case (r_cap_idx)
                    2'd0:    r_buf[7:0]   <= mem_din;
                    2'd1:    r_buf[15:8]  <= mem_din;
                    2'd2:    r_buf[23:16] <= mem_din;
                    default: ;
                endcase
            end
            if (cancel_i) r_cancel <= 1'b1;
            if (flush_i)  r_flush  <= 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    r_valid <= w_hit;
                    if (w_hit) r_inst <= w_rd_data;
                    if (w_accept && !w_hit) begin
                        r_state     <= c_ST_REFILL;
                        r_waddr     <= addr_i[c_WA_W+1:2];
                        r_issue_cnt <= '0;
                        r_cancel    <= 1'b0;
                        r_flush     <= 1'b0;
                    end
                end
                c_ST_REFILL: begin
                    r_valid <= 1'b0;
                    if (w_last) begin
                        r_state <= c_ST_RESP;
                        r_valid <= ~(r_cancel | cancel_i);
                        r_inst  <= w_word;
                    end
                end
                c_ST_RESP: begin
                    r_valid <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign inst_o     = r_inst;
    // A redirect arriving in the response cycle still kills the pulse.
    assign valid_o    = r_valid & ~((r_state == c_ST_RESP) & cancel_i);
    assign busy_o     = (r_state != c_ST_IDLE);
    assign mem_req_o  = (r_state == c_ST_REFILL);
    assign mem_addr_o = mem_req_o ? {{c_PAD_W{1'b0}}, r_waddr, w_k} : '0;

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache
// Description : Self-checking bench for icache: directed vector table, reset
//               sequence, and random traffic against a line-level cache model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        cancel_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] inst_o;
    logic        valid_o;
    logic        busy_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_grant_i = 1'b0;
    logic [7:0]  mem_din = '0;

    localparam int MAXC = 40;

    always #5 clk = ~clk;

    icache dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .cancel_i    (cancel_i),
        .flush_i     (flush_i),
        .inst_o      (inst_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_grant_i (mem_grant_i),
        .mem_din     (mem_din)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Backing memory: fixed program bytes at 0x104, a hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] t;
        case (a)
            32'h104: return 8'h13;
            32'h105: return 8'h05;
            32'h106: return 8'h10;
            32'h107: return 8'h00;
            default: begin
                t = a[7:0] * 8'd29;
                return t ^ a[15:8] ^ {6'h15, a[17:16]};
            end
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {mem_byte(b + 3), mem_byte(b + 2), mem_byte(b + 1), mem_byte(b)};
    endfunction

    // Bus slave: a byte issued in one cycle is returned in the next; junk otherwise.
    logic        iss_q = 1'b0;
    logic [31:0] iss_a = '0;
    always @(negedge clk) begin
        iss_q = mem_req_o & mem_grant_i;
        iss_a = mem_addr_o;
    end
    always @(posedge clk) begin
        #1;
        mem_din = iss_q ? mem_byte(iss_a) : 8'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Observed results of the last transaction
    int          t_vcnt, t_vcyc, t_busy, t_t4, t_gcnt, t_niss, t_last;
    logic [31:0] t_inst;
    logic [31:0] t_iss [4];
    bit          t_done, t_reqseen;

    // gmode < 0: random grant; otherwise grant drops for gmode cycles after byte 1.
    // cc/fl: 0 none, -1 in the request cycle, c>0 in cycle c after it.
    task automatic run_txn(input logic [31:0] a, input int gmode, input int cc, input int fl);
        bit g;
        @(posedge clk); #1;
        req_i = 1'b1; addr_i = a; cancel_i = (cc == -1); flush_i = (fl == -1); mem_grant_i = 1'b0;
        @(negedge clk);
        t_vcnt = 0; t_vcyc = 0; t_busy = 0; t_t4 = 0; t_gcnt = 0; t_niss = 0; t_last = 0;
        t_inst = '0; t_done = 1'b0; t_reqseen = 1'b0;
        for (int k = 0; k < 4; k++) t_iss[k] = '0;
        for (int c = 1; c <= MAXC; c++) begin
            @(posedge clk); #1;
            req_i = 1'b0; addr_i = $urandom; cancel_i = (cc == c); flush_i = (fl == c);
            if (gmode < 0) g = (($urandom % 3) != 0);
            else           g = !(c >= 3 && c < 3 + gmode);
            mem_grant_i = g;
            if (g) begin
                t_gcnt++;
                if (t_gcnt == 4) t_t4 = c;
            end
            @(negedge clk);
            if (valid_o) begin t_vcnt++; t_vcyc = c; t_inst = inst_o; end
            if (busy_o) t_busy++;
            if (mem_req_o) t_reqseen = 1'b1;
            if (mem_req_o && mem_grant_i && t_niss < 4) begin
                t_iss[t_niss] = mem_addr_o;
                t_niss++;
            end
            if (!busy_o) begin t_done = 1'b1; t_last = c; break; end
        end
    endtask

    // Expected behaviour derived from grant count: response sits two cycles after the 4th grant.
    task automatic check_txn(input string nm, input bit exp_miss, input bit exp_valid,
                             input logic [31:0] exp_inst, input logic [31:0] a);
        int L;
        L = t_t4 + 2;
        chk({nm, " done"}, 32'(t_done), 32'd1);
        if (exp_miss) begin
            chk({nm, " busy_len"}, 32'(t_busy), 32'(L));
            chk({nm, " issued"}, 32'(t_niss), 32'd4);
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s addr%0d", nm, k), t_iss[k], {a[31:2], 2'b00} + 32'(k));
        end else begin
            chk({nm, " busy_len"}, 32'(t_busy), 32'd0);
            chk({nm, " mem_req"}, 32'(t_reqseen), 32'd0);
        end
        chk({nm, " valid_cnt"}, 32'(t_vcnt), 32'(exp_valid));
        if (exp_valid) begin
            chk({nm, " valid_cyc"}, 32'(t_vcyc), exp_miss ? 32'(L) : 32'd1);
            chk({nm, " inst"}, t_inst, exp_inst);
        end
    endtask

    // Reference model: one valid bit and tag per line
    bit          mv [32];
    logic [10:0] mt [32];

    task automatic model_clear();
        for (int k = 0; k < 32; k++) mv[k] = 1'b0;
    endtask

    task automatic rand_txn();
        logic [4:0]  idx;
        logic [10:0] tg;
        logic [15:0] wa;
        logic [31:0] a;
        int cc, fl, L;
        bit drop, hit, miss, expv;
        idx = 5'($urandom_range(0, 7));
        tg  = 11'($urandom_range(0, 3));
        wa  = {tg, idx};
        a   = {14'd0, wa, 2'($urandom)};
        cc = 0; fl = 0;
        if (($urandom % 100) < 12) cc = (($urandom % 4) == 0) ? -1 : int'($urandom_range(1, 7));
        if (($urandom % 100) < 8)  fl = (($urandom % 4) == 0) ? -1 : int'($urandom_range(1, 7));
        drop = (cc == -1);
        if (fl == -1) model_clear();
        hit  = !drop && (fl != -1) && mv[idx] && (mt[idx] == tg);
        miss = !drop && !hit;
        run_txn(a, -1, cc, fl);
        L = t_t4 + 2;
        expv = hit || (miss && !(cc >= 1 && cc <= L));
        check_txn("rand", miss, expv, mem_word(a), a);
        if (fl >= 1 && fl <= t_last) model_clear();
        else if (miss) begin mv[idx] = 1'b1; mt[idx] = tg; end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          gap;
        int          cc;
        int          fl;
        bit          exp_valid;
        int          exp_cyc;
        logic [31:0] exp_inst;
        int          exp_busy;
    } vec_t;

    vec_t tv [16];
    int   vc;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{32'h104,  0,  0,  0, 1'b1, 6, 32'h00100513,     6};
        tv[1]  = '{32'h104,  0,  0,  0, 1'b1, 1, 32'h00100513,     0};
        tv[2]  = '{32'h208,  2,  0,  0, 1'b1, 8, mem_word(32'h208), 8};
        tv[3]  = '{32'h30C,  0,  3,  0, 1'b0, 0, 32'h0,            6};
        tv[4]  = '{32'h30C,  0,  0,  0, 1'b1, 1, mem_word(32'h30C), 0};
        tv[5]  = '{32'h410,  0,  0,  2, 1'b1, 6, mem_word(32'h410), 6};
        tv[6]  = '{32'h410,  0,  0,  0, 1'b1, 6, mem_word(32'h410), 6};
        tv[7]  = '{32'h104,  0,  0,  0, 1'b1, 6, 32'h00100513,     6};
        tv[8]  = '{32'h410,  0,  0,  0, 1'b1, 1, mem_word(32'h410), 0};
        tv[9]  = '{32'h1104, 0,  0,  0, 1'b1, 6, mem_word(32'h1104), 6};
        tv[10] = '{32'h104,  0,  0,  0, 1'b1, 6, 32'h00100513,     6};
        tv[11] = '{32'h104,  0, -1,  0, 1'b0, 0, 32'h0,            0};
        tv[12] = '{32'h104,  0,  0, -1, 1'b1, 6, 32'h00100513,     6};
        tv[13] = '{32'h107,  0,  0,  0, 1'b1, 1, 32'h00100513,     0};
        tv[14] = '{32'h514,  0,  6,  0, 1'b0, 0, 32'h0,            6};
        tv[15] = '{32'h514,  0,  0,  0, 1'b1, 1, mem_word(32'h514), 0};

        #2 rst = 1'b0;
        #1;
        chk("reset valid_o",    32'(valid_o),   32'd0);
        chk("reset busy_o",     32'(busy_o),    32'd0);
        chk("reset mem_req_o",  32'(mem_req_o), 32'd0);
        chk("reset mem_addr_o", mem_addr_o,     32'd0);
        chk("reset inst_o",     inst_o,         32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_txn(tv[i].addr, tv[i].gap, tv[i].cc, tv[i].fl);
            check_txn($sformatf("vec%0d", i), tv[i].exp_busy != 0, tv[i].exp_valid,
                      tv[i].exp_inst, tv[i].addr);
            chk($sformatf("vec%0d busy_const", i), 32'(t_busy), 32'(tv[i].exp_busy));
            if (tv[i].exp_valid)
                chk($sformatf("vec%0d cyc_const", i), 32'(t_vcyc), 32'(tv[i].exp_cyc));
        end

        // Reset in the middle of a refill
        @(posedge clk); #1;
        req_i = 1'b1; addr_i = 32'h600; cancel_i = 1'b0; flush_i = 1'b0; mem_grant_i = 1'b1;
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_refill busy_o", 32'(busy_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst valid_o",    32'(valid_o),   32'd0);
        chk("mid_rst busy_o",     32'(busy_o),    32'd0);
        chk("mid_rst mem_req_o",  32'(mem_req_o), 32'd0);
        chk("mid_rst mem_addr_o", mem_addr_o,     32'd0);
        chk("mid_rst inst_o",     inst_o,         32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vc = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid_o || busy_o) vc++;
        end
        chk("post_rst quiet", 32'(vc), 32'd0);
        model_clear();
        run_txn(32'h600, 0, 0, 0);
        check_txn("post_rst 0x600", 1'b1, 1'b1, mem_word(32'h600), 32'h600);
        run_txn(32'h104, 0, 0, 0);
        check_txn("post_rst 0x104", 1'b1, 1'b1, 32'h00100513, 32'h104);
        mv[0] = 1'b1; mt[0] = 11'd12;
        mv[1] = 1'b1; mt[1] = 11'd2;

        for (int i = 0; i < 150; i++) rand_txn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
